// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter that shares one SR latch between N requesters and drives fixed-width s/r pulses.
// Optional feature: define SR_ARB_SKIP_REDUNDANT_EN to skip pulses that would not change the flag.
module sr_flag_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned PULSE_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         set_req,
  input  logic [N-1:0]         clr_req,
  output logic [N-1:0]         ack,
  output logic [N-1:0]         err,
  output logic                 s,
  output logic                 r,
  output logic                 q_track,
  output logic                 busy,
  output logic [$clog2(N)-1:0] gnt_id
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE   = 2'd1,
    RECOVER = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            op_set, op_set_n;
  logic [IW-1:0]   ptr, ptr_n;
  logic [IW-1:0]   gnt_n;
  logic            q_n, s_n, r_n, busy_n;
  logic [N-1:0]    ack_n, err_n;

  logic [N-1:0]    pend;
  logic            found;
  logic [IW-1:0]   win;
  logic            win_set, win_clr, win_both;
  logic            redundant;
  logic [IW-1:0]   win_next;

  assign pend = set_req | clr_req;

  // First pending requester at or above ptr, wrapping modulo N.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!found && pend[IW'((32'(ptr) + k) % N)]) begin
        found = 1'b1;
        win   = IW'((32'(ptr) + k) % N);
      end
    end
  end

  assign win_set  = set_req[win];
  assign win_clr  = clr_req[win];
  assign win_both = win_set & win_clr;
  assign win_next = (win == IW'(N - 1)) ? '0 : win + IW'(1);

`ifdef SR_ARB_SKIP_REDUNDANT_EN
  // A pulse that would leave the latch unchanged is acknowledged without driving s/r.
  assign redundant = !win_both && ((win_set && q_track) || (win_clr && !q_track));
`else
  assign redundant = 1'b0;
`endif

  function automatic logic [N-1:0] onehot(input logic [IW-1:0] idx);
    logic [N-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // State and registered-output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      op_set  <= 1'b0;
      ptr     <= '0;
      gnt_id  <= '0;
      q_track <= 1'b0;
      s       <= 1'b0;
      r       <= 1'b0;
      ack     <= '0;
      err     <= '0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      op_set  <= op_set_n;
      ptr     <= ptr_n;
      gnt_id  <= gnt_n;
      q_track <= q_n;
      s       <= s_n;
      r       <= r_n;
      ack     <= ack_n;
      err     <= err_n;
      busy    <= busy_n;
    end
  end

  // Next-state and next-output logic; s/r/ack are computed one cycle ahead and registered.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    op_set_n = op_set;
    ptr_n    = ptr;
    gnt_n    = gnt_id;
    q_n      = q_track;
    s_n      = 1'b0;
    r_n      = 1'b0;
    ack_n    = '0;
    err_n    = '0;

    unique case (state)
      IDLE: begin
        if (found) begin
          gnt_n    = win;
          ptr_n    = win_next;
          op_set_n = win_set;
          if (win_both) begin
            state_n = RECOVER;
            ack_n   = onehot(win);
            err_n   = onehot(win);
          end else if (redundant) begin
            state_n = RECOVER;
            ack_n   = onehot(win);
          end else begin
            state_n = PULSE;
            cnt_n   = CW'(PULSE_W - 1);
            s_n     = win_set;
            r_n     = !win_set;
          end
        end
      end

      PULSE: begin
        if (cnt == '0) begin
          state_n = RECOVER;
          q_n     = op_set;
          ack_n   = onehot(gnt_id);
        end else begin
          cnt_n = cnt - CW'(1);
          s_n   = op_set;
          r_n   = !op_set;
        end
      end

      RECOVER: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

`ifndef SYNTHESIS
  // Latch-safety and handshake invariants.
  a_sr_exclusive: assert property (@(posedge clk) disable iff (rst) !(s && r));
  a_ack_onehot0:  assert property (@(posedge clk) disable iff (rst) $onehot0(ack));
  a_err_with_ack: assert property (@(posedge clk) disable iff (rst) (err & ~ack) == '0);
  a_quiet_idle:   assert property (@(posedge clk) disable iff (rst)
                                   (state != PULSE) |-> !(s || r));
`endif

endmodule

// File: doc/sr_flag_arbiter.md
# sr_flag_arbiter

Clocked controller that shares one SR latch (a single status flag) between N requesters. It serialises set/clear requests with round-robin arbitration and drives the latch's `s`/`r` inputs with fixed-width pulses. It guarantees `s` and `r` are never high together and inserts a recovery gap between operations. It sits between the requesting logic and the `s`/`r` pins of the latch, and keeps a registered copy of the flag value it has commanded.

## Interface
Parameters:
- `N`, 4: number of requesters (2..16).
- `PULSE_W`, 2: cycles that `s` or `r` is held high per operation (1..15).

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `set_req`  in  N: bit i high = requester i asks to set the flag; level, held until `ack[i]`.
- `clr_req`  in  N: bit i high = requester i asks to clear the flag; level, held until `ack[i]`.
- `ack`  out  N: one-cycle completion pulse to the granted requester.
- `err`  out  N: one-cycle pulse, coincident with `ack[i]`, when requester i had both requests high at grant.
- `s`  out  1: latch set drive (registered).
- `r`  out  1: latch reset drive (registered).
- `q_track`  out  1: last value commanded onto the latch.
- `busy`  out  1: high in any state other than IDLE.
- `gnt_id`  out  clog2(N): index of the current or last granted requester.

## Operation
- Requester i is *pending* when `set_req[i] | clr_req[i]`.
- FSM states:
  - IDLE: if any requester is pending, grant the first pending index searching upward (modulo N) from pointer `ptr`.
    - If only `set_req[i]` is high, go to PULSE with op=SET. If only `clr_req[i]` is high, go to PULSE with op=CLR.
    - If both are high, go to RECOVER with the error flag set; no pulse is issued.
    - Latch `gnt_id`=i and set `ptr`=(i+1) mod N.
  - PULSE: `s`=1 (SET) or `r`=1 (CLR) for exactly `PULSE_W` cycles, counted by a down-counter. On the last cycle, load `q_track` with 1 (SET) or 0 (CLR) and go to RECOVER.
  - RECOVER: `s`=`r`=0 for one cycle. `ack[gnt_id]`=1, and `err[gnt_id]`=1 if the error flag is set. Then go to IDLE.
- Invariants:
  - `s & r` is never 1.
  - At most one `ack` bit is high in any cycle.
  - `s` and `r` are low in IDLE and RECOVER.
- Requester obligations:
  - Keep the request stable until `ack`.
  - Deassert the request in the cycle after `ack`.
  - The IDLE cycle that follows RECOVER evaluates requests. Because `ptr` has already advanced past the acked requester, a lingering request from it cannot win while others are pending.
- Request changes during PULSE or RECOVER have no effect until the next IDLE.

## Timing
- Reset values: `s`=0, `r`=0, `ack`=0, `err`=0, `q_track`=0, `busy`=0, `gnt_id`=0; internal `ptr`=0; state IDLE.
- Latency: request first sampled in IDLE at edge E0:
  - `s`/`r` high in cycles E0+1 .. E0+`PULSE_W`.
  - `ack` high in cycle E0+`PULSE_W`+1.
- Throughput: one operation per `PULSE_W`+2 cycles while requests are continuously pending. A conflict operation takes 2 cycles (IDLE, RECOVER).
- `ptr` wraps from N-1 to 0.
- `rst` asserted mid-PULSE: at the next edge `s`/`r` drop to 0 and the pulse is abandoned. No `ack` is issued and all state returns to reset values. `q_track` becomes 0 regardless of the physical latch state.

## Configuration
- `SR_ARB_SKIP_REDUNDANT_EN`
  - Defined: in IDLE, a non-conflicting grant whose op matches `q_track` (SET while `q_track`=1, CLR while `q_track`=0) skips PULSE. The FSM goes directly to RECOVER with `ack` and no `s`/`r` activity, so that operation takes 2 cycles.
  - Undefined: every non-conflicting grant issues a full `PULSE_W` pulse.

## Test plan
- Reset, then `set_req`=4'b0001, `PULSE_W`=2: `s`=1 for 2 cycles, then `ack`=4'b0001 one cycle later, `q_track`=1, `r` never high.
- `set_req`=4'b0100 and `clr_req`=4'b0010 together from reset: requester 1 is granted first (CLR, `gnt_id`=1), then requester 2 (SET). `ack` sequence is 4'b0010 then 4'b0100, spaced 4 cycles apart. Final `q_track`=1.
- All four requesters held pending for 8 operations: grant order 0,1,2,3,0,1,2,3 (round-robin wrap), and `s & r` stays 0 throughout.
- `set_req[3]`=`clr_req[3]`=1: no `s`/`r` activity, `ack`=`err`=4'b1000 in the second cycle, `q_track` unchanged.
- `rst` pulsed during the second `s` cycle: `s`=0 and `busy`=0 next cycle, no `ack`, `gnt_id`=0.
- With `SR_ARB_SKIP_REDUNDANT_EN` defined and `q_track`=1, `set_req[0]`: `ack` arrives 2 cycles after sampling with no `s` pulse. Without the macro, a 2-cycle `s` pulse is issued.
